// File: rtl/uart_pkg.sv
// Shared definitions for the CSR mailbox UART host bridge: mailbox offsets,
// word encoding and the bridge state encoding.
package uart_pkg;

  localparam logic [3:0]  UART_OFS_RX   = 4'h0;
  localparam logic [3:0]  UART_OFS_TX   = 4'h1;
  localparam int unsigned UART_FULL_BIT = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRdRx,
    StChkRx,
    StWrRx,
    StRdTx,
    StChkTx,
    StClrTx,
    StGap
  } uart_bridge_state_e;

  function automatic logic [13:0] uart_csr_addr(input logic [3:0] bank, input logic [3:0] ofs);
    return {bank, 6'b0, ofs};
  endfunction

endpackage

// File: rtl/uart_bridge_gap_timer.sv
// Countdown for the post-poll idle gap: load starts a Gap-cycle window and
// expired_o marks its final cycle.
module uart_bridge_gap_timer #(
  parameter int unsigned Gap = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic expired_o
);

  localparam int unsigned     CntW    = $clog2(Gap + 1);
  localparam logic [CntW-1:0] GapLoad = CntW'(Gap);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = GapLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/uart_host_bridge.sv
// Host-side agent for the CSR mailbox UART: posts stream bytes into RX and drains TX.
// Define UART_HOST_BRIDGE_GAP_EN to idle POLL_GAP cycles after each unproductive poll.
module uart_host_bridge
  import uart_pkg::*;
#(
  parameter logic [3:0]  csr_addr = 4'h0,
  parameter int unsigned POLL_GAP = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_di,
  input  logic [31:0] csr_do,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready
);

  localparam logic [13:0] AddrRx = uart_csr_addr(csr_addr, UART_OFS_RX);
  localparam logic [13:0] AddrTx = uart_csr_addr(csr_addr, UART_OFS_TX);

  uart_bridge_state_e state_q;
  logic [13:0]        csr_a_q;
  logic               csr_we_q;
  logic [31:0]        csr_di_q;
  logic               tx_ready_q;
  logic [7:0]         rx_data_q;
  logic               rx_valid_q;
  logic               send_first_q;
  logic               gap_expired;

`ifdef UART_HOST_BRIDGE_GAP_EN
  localparam uart_bridge_state_e StAfterPoll = StGap;

  logic gap_load;

  // Loads exactly on the CHK -> GAP transition.
  assign gap_load = ((state_q == StChkRx) && (csr_do != '0)) ||
                    ((state_q == StChkTx) && !csr_do[UART_FULL_BIT]);

  uart_bridge_gap_timer #(
    .Gap (POLL_GAP)
  ) u_gap_timer (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .load_i    (gap_load),
    .expired_o (gap_expired)
  );
`else
  localparam uart_bridge_state_e StAfterPoll = StIdle;

  assign gap_expired = 1'b1;

  // POLL_GAP only shapes the build with the gap enabled.
  if (POLL_GAP == 0) begin : g_no_gap
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      csr_a_q      <= '0;
      csr_we_q     <= 1'b0;
      csr_di_q     <= '0;
      tx_ready_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      send_first_q <= 1'b1;
    end else begin
      csr_we_q   <= 1'b0;
      csr_di_q   <= '0;
      tx_ready_q <= 1'b0;
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          // Send wins when it is its turn or when receive has nothing to ask for.
          if (tx_valid && (send_first_q || rx_valid_q)) begin
            state_q      <= StRdRx;
            csr_a_q      <= AddrRx;
            send_first_q <= 1'b0;
          end else if (!rx_valid_q) begin
            state_q      <= StRdTx;
            csr_a_q      <= AddrTx;
            send_first_q <= 1'b1;
          end
        end
        StRdRx:  state_q <= StChkRx;
        StChkRx: begin
          if (csr_do == '0) begin
            state_q    <= StWrRx;
            csr_we_q   <= 1'b1;
            csr_di_q   <= {23'b0, 1'b1, tx_data};
            tx_ready_q <= 1'b1;
          end else begin
            state_q <= StAfterPoll;
          end
        end
        StWrRx:  state_q <= StIdle;
        StRdTx:  state_q <= StChkTx;
        StChkTx: begin
          if (csr_do[UART_FULL_BIT]) begin
            state_q   <= StClrTx;
            csr_we_q  <= 1'b1;
            rx_data_q <= csr_do[7:0];
          end else begin
            state_q <= StAfterPoll;
          end
        end
        StClrTx: begin
          state_q    <= StIdle;
          rx_valid_q <= 1'b1;
        end
        StGap: begin
          if (gap_expired) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign csr_a    = csr_a_q;
  assign csr_we   = csr_we_q;
  assign csr_di   = csr_di_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: doc/uart_host_bridge.md
# uart_host_bridge

Hardware host-side agent for the CSR mailbox UART: a CSR bus initiator that runs the host half of the mailbox protocol on its own. Bytes from an external stream are posted to the CPU through the RX mailbox register. Bytes the CPU posts in the TX mailbox register are drained and presented on an output stream. It sits between the mailbox's CSR port and a byte-stream source/sink such as a JTAG shifter or a physical serial PHY.

## Interface
- `csr_addr`, default 4'h0: CSR bank of the target mailbox; all issued addresses are {csr_addr, 6'b0, offset[3:0]}.
- `POLL_GAP`, default 16: idle cycles between unproductive poll rounds (only with the gap macro).
- `sys_clk` in 1: sole clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `csr_a` out 14: CSR address.
- `csr_we` out 1: CSR write strobe.
- `csr_di` out 32: CSR write data.
- `csr_do` in 32: CSR read data, registered by the target; valid the cycle after the address is presented.
- `tx_data` in 8: byte to deliver to the CPU.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: one-cycle pulse; the byte is consumed this cycle.
- `rx_data` out 8: byte received from the CPU.
- `rx_valid` out 1: `rx_data` is valid; held until accepted.
- `rx_ready` in 1: sink accepts when `rx_valid` and `rx_ready` are both high.

## Operation
- Mailbox map: offset 0 is RX (host→CPU); offset 1 is TX (CPU→host).
- Word encoding: bit 8 is the full flag, bits 7:0 are data, and zero means empty.
- States:
  - IDLE
  - RD_RX: issue a read of offset 0.
  - CHK_RX: sample `csr_do`.
  - WR_RX: write {23'b0, 1'b1, tx_data}, pulse `tx_ready`.
  - RD_TX: issue a read of offset 1.
  - CHK_TX: sample `csr_do`.
  - CLR_TX: write 0 to offset 1, load the rx buffer.
  - GAP
- IDLE arbitration is round-robin between two requests; the last-served side has lower priority.
  - Send request: `tx_valid`.
  - Receive request: the rx buffer is empty.
- Send path: IDLE→RD_RX→CHK_RX.
  - If the sampled word is 0, go to WR_RX, then IDLE.
  - If nonzero, return to IDLE; the poll was unproductive.
- Receive path: IDLE→RD_TX→CHK_TX.
  - If bit 8 is set, capture bits 7:0 and go to CLR_TX, then IDLE.
  - Otherwise, return to IDLE; the poll was unproductive.
- The rx buffer is one byte with `rx_valid` as its full flag. It clears on handshake. It loads only in CLR_TX, which is reachable only while the buffer is empty.
- `tx_data` must stay stable while `tx_valid` is high until `tx_ready`. The bridge never writes RX unless it has just read 0, and never clears TX unless it has just read a set flag.
- Bus outputs in non-access states: `csr_we`=0, `csr_di`=0, `csr_a` holds its last value.

## Timing
- Reset values: `csr_a`=0, `csr_we`=0, `csr_di`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, state IDLE, arbitration pointer = send-first.
- Read access: address is driven in cycle N and `csr_do` is sampled at the end of N+1. Write access is one cycle with `csr_we`=1.
- Send, mailbox empty, no competing request: `tx_valid` rising in IDLE gives `tx_ready` 3 cycles later (RD_RX, CHK_RX, WR_RX).
- Receive: `rx_valid` rises the cycle after CLR_TX, 4 cycles after leaving IDLE.
- Simultaneous requests: the side not served last goes first; the other is served in the next round.
- `tx_valid` deasserting mid-path is a protocol violation; the behaviour is undefined and not checked.
- `sys_rst_n` mid-access aborts at once. A lost CLR_TX leaves TX full and it is re-read after reset. A lost WR_RX simply never happened. No duplicate delivery is possible from a single aborted cycle.

## Configuration
- `UART_HOST_BRIDGE_GAP_EN` defined: any return to IDLE after an unproductive poll passes through GAP for `POLL_GAP` cycles. A counter sized $clog2(POLL_GAP+1) counts down; new requests are ignored until it expires.
- Undefined: GAP and its counter are absent, and polls run back-to-back.

## Structure
- Package `uart_pkg`:
  - offsets `UART_OFS_RX`=4'h0 and `UART_OFS_TX`=4'h1
  - `UART_FULL_BIT`=8
  - the bridge state enum
- Sub-module `uart_bridge_gap_timer` holds the GAP countdown (load/expire). It is instantiated only under the macro.

## Test plan
- Send with mailbox empty: model returns 0 on offset 0, `tx_data`=0x41. Expect a write of 0x00000141 to offset 0 and `tx_ready` exactly 3 cycles after `tx_valid`.
- Send with RX busy: model returns 0x141 for 3 polls, then 0. Expect no write during the busy polls, then a single write and a single `tx_ready`.
- Receive: model TX=0x15A. Expect a write of 0 to offset 1, then `rx_data`=0x5A with `rx_valid` held while `rx_ready`=0 for 5 cycles; it clears on the handshake cycle.
- Contention: `tx_valid` high and TX=0x1FF simultaneously. Expect round-robin alternation and both bytes delivered, with the send path first after reset.
- Gap (macro on, `POLL_GAP`=4): TX and RX both unproductive. Expect exactly 4 idle bus cycles between poll rounds; with the macro off, 0.
- Reset mid-CHK_TX with TX=0x1AA: deassert reset. Expect TX re-read and 0xAA delivered exactly once.
